inbuf_fifo: RTL and testbench

Synchronous single-clock FIFO holding incoming data lines that await encoding; sits directly upstream of the input buffer controller and feeds the encoding engine's data-line register. The host/DMA side pushes full data lines. The controller pops one line per request, with fixed one-cycle read latency, into a held output register that the engine consumes M times. Status flags, occupancy and sticky error flags go back to the controller and the host.

---
 rtl/inbuf_fifo.sv | 142 ++++++++++++++
 tb/tb_inbuf_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inbuf_fifo.sv
// inbuf_fifo: single-clock FIFO of data lines awaiting encoding, with a held
// one-cycle-latency output register, registered status flags and sticky errors.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   eng_flush                synchronous flush (engine reset), empties the FIFO
//   host_inbuf_wr_en/_data   host write request and line
//   inbuf_host_full/_afull   occupancy == DEPTH / occupancy >= AFULL_THRESH
//   cntl_inbuf_fifo_rd_rq    controller read request (needs _mem_en too)
//   cntl_inbuf_fifo_mem_en   memory enable
//   inbuf_fifo_cntl_empty    occupancy == 0
//   inbuf_fifo_count         occupancy 0..DEPTH
//   inbuf_eng_dout           held output line
//   inbuf_eng_dout_val       output holds a valid line (sticky until flush/rst)
//   inbuf_eng_rd_data_val    one-cycle pulse when a new line is loaded
//   inbuf_ovf_err/_udf_err   sticky overflow / underflow attempt flags
module inbuf_fifo #(
    parameter int DATA_W       = 128,
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int AFULL_THRESH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eng_flush,
    input  logic              host_inbuf_wr_en,
    input  logic [DATA_W-1:0] host_inbuf_wr_data,
    output logic              inbuf_host_full,
    output logic              inbuf_host_afull,
    input  logic              cntl_inbuf_fifo_rd_rq,
    input  logic              cntl_inbuf_fifo_mem_en,
    output logic              inbuf_fifo_cntl_empty,
    output logic [ADDR_W:0]   inbuf_fifo_count,
    output logic [DATA_W-1:0] inbuf_eng_dout,
    output logic              inbuf_eng_dout_val,
    output logic              inbuf_eng_rd_data_val,
    output logic              inbuf_ovf_err,
    output logic              inbuf_udf_err
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_AFULL = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wp;
    logic [ADDR_W-1:0] r_rp;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_afull;
    logic              r_empty;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_val;
    logic              r_rd_val;
    logic              r_ovf;
    logic              r_udf;

    logic              w_rd_att;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_cnt_nxt;

    // Acceptance uses the registered full/empty flags, so a read never
    // frees room for a same-cycle write and a write never falls through.
    assign w_rd_att = cntl_inbuf_fifo_rd_rq & cntl_inbuf_fifo_mem_en;
    assign w_wr_acc = host_inbuf_wr_en & ~r_full & ~eng_flush;
    assign w_rd_acc = w_rd_att & ~r_empty & ~eng_flush;

    always_comb begin
        w_cnt_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_cnt_nxt = r_count + LP_ONE;
            2'b01:   w_cnt_nxt = r_count - LP_ONE;
            default: w_cnt_nxt = r_count;
        endcase
    end

    // Storage array carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wp] <= host_inbuf_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_empty    <= 1'b1;
            r_dout     <= '0;
            r_dout_val <= 1'b0;
            r_rd_val   <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else if (eng_flush) begin
            // Output data and error history survive a flush.
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_afull    <= 1'b0;
            r_empty    <= 1'b1;
            r_dout_val <= 1'b0;
            r_rd_val   <= 1'b0;
        end else begin
            // Pointers wrap naturally: DEPTH is a power of two.
            if (w_wr_acc) begin
                r_wp <= r_wp + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rp       <= r_rp + ADDR_W'(1);
                r_dout     <= r_mem[r_rp];
                r_dout_val <= 1'b1;
            end
            r_rd_val <= w_rd_acc;
            r_count  <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == LP_DEPTH);
            r_afull  <= (w_cnt_nxt >= LP_AFULL);
            r_empty  <= (w_cnt_nxt == '0);
            if (host_inbuf_wr_en && r_full) begin
                r_ovf <= 1'b1;
            end
            if (w_rd_att && r_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign inbuf_host_full       = r_full;
    assign inbuf_host_afull      = r_afull;
    assign inbuf_fifo_cntl_empty = r_empty;
    assign inbuf_fifo_count      = r_count;
    assign inbuf_eng_dout        = r_dout;
    assign inbuf_eng_dout_val    = r_dout_val;
    assign inbuf_eng_rd_data_val = r_rd_val;
    assign inbuf_ovf_err         = r_ovf;
    assign inbuf_udf_err         = r_udf;

endmodule

// File: tb/tb_inbuf_fifo.sv
// tb_inbuf_fifo: queue-based reference model with per-cycle compare, directed
// boundary scenarios with literal expectations, then randomized traffic.
module tb_inbuf_fifo;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int AF     = 6;

    typedef logic [DATA_W-1:0] line_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              wr = 1'b0;
    logic              rq = 1'b0;
    logic              me = 1'b0;
    line_t             wd = '0;
    logic              o_full;
    logic              o_afull;
    logic              o_empty;
    logic [ADDR_W:0]   o_count;
    line_t             o_dout;
    logic              o_val;
    logic              o_rdv;
    logic              o_ovf;
    logic              o_udf;

    inbuf_fifo #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .AFULL_THRESH(AF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .eng_flush(flush),
        .host_inbuf_wr_en(wr),
        .host_inbuf_wr_data(wd),
        .inbuf_host_full(o_full),
        .inbuf_host_afull(o_afull),
        .cntl_inbuf_fifo_rd_rq(rq),
        .cntl_inbuf_fifo_mem_en(me),
        .inbuf_fifo_cntl_empty(o_empty),
        .inbuf_fifo_count(o_count),
        .inbuf_eng_dout(o_dout),
        .inbuf_eng_dout_val(o_val),
        .inbuf_eng_rd_data_val(o_rdv),
        .inbuf_ovf_err(o_ovf),
        .inbuf_udf_err(o_udf)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input line_t act, input line_t exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a queue of stored lines plus the output-side state.
    line_t q[$];
    line_t m_dout = '0;
    bit    m_val = 0;
    bit    m_rdv = 0;
    bit    m_ovf = 0;
    bit    m_udf = 0;

    always @(posedge clk) begin : model
        bit is_full;
        bit is_empty;
        bit ra;
        bit wa;
        if (rst) begin
            q.delete();
            m_dout = '0;
            m_val = 0;
            m_rdv = 0;
            m_ovf = 0;
            m_udf = 0;
        end else if (flush) begin
            q.delete();
            m_val = 0;
            m_rdv = 0;
        end else begin
            is_full  = (q.size() == DEPTH);
            is_empty = (q.size() == 0);
            if (wr && is_full) m_ovf = 1;
            if (rq && me && is_empty) m_udf = 1;
            ra = rq && me && !is_empty;
            wa = wr && !is_full;
            m_rdv = ra;
            if (ra) begin
                m_dout = q.pop_front();
                m_val = 1;
            end
            if (wa) q.push_back(wd);
        end
    end

    always @(negedge clk) begin : compare
        chk("count", line_t'(o_count), line_t'(q.size()));
        chk("full", line_t'(o_full), line_t'(q.size() == DEPTH));
        chk("afull", line_t'(o_afull), line_t'(q.size() >= AF));
        chk("empty", line_t'(o_empty), line_t'(q.size() == 0));
        chk("dout", o_dout, m_dout);
        chk("dout_val", line_t'(o_val), line_t'(m_val));
        chk("rd_data_val", line_t'(o_rdv), line_t'(m_rdv));
        chk("ovf_err", line_t'(o_ovf), line_t'(m_ovf));
        chk("udf_err", line_t'(o_udf), line_t'(m_udf));
    end

    // One cycle of stimulus, then return inputs to idle.
    task automatic step(input bit w, input line_t d, input bit r, input bit f);
        wr = w;
        wd = d;
        rq = r;
        me = r;
        flush = f;
        @(negedge clk);
        wr = 0;
        rq = 0;
        me = 0;
        flush = 0;
    endtask

    task automatic chk_reset_state();
        chk("rst_full", line_t'(o_full), line_t'(0));
        chk("rst_afull", line_t'(o_afull), line_t'(0));
        chk("rst_empty", line_t'(o_empty), line_t'(1));
        chk("rst_count", line_t'(o_count), line_t'(0));
        chk("rst_dout", o_dout, line_t'(0));
        chk("rst_val", line_t'(o_val), line_t'(0));
        chk("rst_rdv", line_t'(o_rdv), line_t'(0));
        chk("rst_ovf", line_t'(o_ovf), line_t'(0));
        chk("rst_udf", line_t'(o_udf), line_t'(0));
    endtask

    initial begin
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        chk_reset_state();

        // Fill and drain
        for (int i = 1; i <= 8; i++) begin
            step(1, line_t'(i), 0, 0);
            chk("fill_count", line_t'(o_count), line_t'(i));
            chk("fill_afull", line_t'(o_afull), line_t'(i >= 6));
            chk("fill_full", line_t'(o_full), line_t'(i == 8));
        end
        for (int i = 1; i <= 8; i++) begin
            step(0, '0, 1, 0);
            chk("drain_dout", o_dout, line_t'(i));
            chk("drain_rdv", line_t'(o_rdv), line_t'(1));
            chk("drain_count", line_t'(o_count), line_t'(8 - i));
        end
        chk("drain_empty", line_t'(o_empty), line_t'(1));

        // Pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1, line_t'(32'h100 + i), 0, 0);
            step(0, '0, 1, 0);
            chk("wrap_dout", o_dout, line_t'(32'h100 + i));
            chk("wrap_count_le1", line_t'(o_count <= 1), line_t'(1));
        end

        // Full boundary
        for (int i = 1; i <= 8; i++) step(1, line_t'(32'h10 + i), 0, 0);
        chk("fb_full", line_t'(o_full), line_t'(1));
        chk("fb_ovf_pre", line_t'(o_ovf), line_t'(0));
        step(1, line_t'(32'hAA), 1, 0);
        chk("fb_dout", o_dout, line_t'(32'h11));
        chk("fb_count", line_t'(o_count), line_t'(7));
        chk("fb_ovf", line_t'(o_ovf), line_t'(1));
        for (int i = 2; i <= 8; i++) begin
            step(0, '0, 1, 0);
            chk("fb_drain", o_dout, line_t'(32'h10 + i));
        end
        chk("fb_no_aa", line_t'(o_empty), line_t'(1));

        // Empty boundary
        step(1, line_t'(32'h55), 1, 0);
        chk("eb_rdv", line_t'(o_rdv), line_t'(0));
        chk("eb_udf", line_t'(o_udf), line_t'(1));
        chk("eb_count", line_t'(o_count), line_t'(1));
        chk("eb_dout_held", o_dout, line_t'(32'h18));
        step(0, '0, 1, 0);
        chk("eb_dout", o_dout, line_t'(32'h55));
        chk("eb_rdv2", line_t'(o_rdv), line_t'(1));

        // Flush mid-operation
        for (int i = 0; i < 5; i++) step(1, line_t'(32'h60 + i), 0, 0);
        chk("fl_pre_count", line_t'(o_count), line_t'(5));
        chk("fl_pre_val", line_t'(o_val), line_t'(1));
        step(1, line_t'(32'h77), 0, 1);
        chk("fl_count", line_t'(o_count), line_t'(0));
        chk("fl_empty", line_t'(o_empty), line_t'(1));
        chk("fl_val", line_t'(o_val), line_t'(0));
        chk("fl_dout", o_dout, line_t'(32'h55));
        chk("fl_ovf", line_t'(o_ovf), line_t'(1));
        chk("fl_udf", line_t'(o_udf), line_t'(1));

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step(1, line_t'(32'h90 + i), 0, 0);
        chk("rm_count", line_t'(o_count), line_t'(3));
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_reset_state();

        // Randomized traffic
        repeat (3000) begin
            wr = ($urandom_range(0, 99) < 55);
            wd = {$urandom, $urandom, $urandom, $urandom};
            rq = ($urandom_range(0, 99) < 50);
            me = ($urandom_range(0, 99) < 85);
            flush = ($urandom_range(0, 99) < 2);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        wr = 0;
        rq = 0;
        me = 0;
        flush = 0;
        rst = 0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
